// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for a word-wide synchronous-read data RAM.
// Performs aligned byte/half/word accesses; sub-word stores are read-modify-write.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 req_i,
  input  logic [1:0]                 we_i,
  input  logic [1:0][1:0]            size_i,
  input  logic [1:0]                 uns_i,
  input  logic [1:0][ADDR_WIDTH-1:0] addr_i,
  input  logic [1:0][DATA_WIDTH-1:0] wdata_i,
  output logic [1:0]                 ack_o,
  output logic [1:0]                 err_o,
  output logic [DATA_WIDTH-1:0]      rdata_o,
  output logic                       busy_o,
  output logic                       mem_we,
  output logic [ADDR_WIDTH-1:0]      mem_a,
  output logic [DATA_WIDTH-1:0]      mem_wd,
  input  logic [DATA_WIDTH-1:0]      mem_rd
);

  localparam int SW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, WR, RD, RESP, MERGE, ERR} state_t;

  state_t                state, state_nx;
  logic                  port_q, we_q, uns_q, rr;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  gnt_port, gnt_ok;
  logic [1:0]            gnt_size;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [SW-1:0]         shamt;
  logic [DATA_WIDTH-1:0] shifted, mask, merged, extracted;
  logic [1:0]            port_hot;

  // On a tie the port not named by rr wins.
  assign gnt_port = (req_i == 2'b11) ? ~rr : req_i[1];
  assign gnt_size = size_i[gnt_port];
  assign gnt_addr = addr_i[gnt_port];

  always_comb begin
    gnt_ok = 1'b0;
    case (gnt_size)
      2'b00:   gnt_ok = 1'b1;
      2'b01:   gnt_ok = ~gnt_addr[0];
      2'b10:   gnt_ok = (gnt_addr[1:0] == 2'b00);
      default: gnt_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr      <= 1'b1;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_i != 2'b00) begin
        rr      <= gnt_port;
        port_q  <= gnt_port;
        we_q    <= we_i[gnt_port];
        uns_q   <= uns_i[gnt_port];
        size_q  <= gnt_size;
        addr_q  <= gnt_addr;
        wdata_q <= wdata_i[gnt_port];
      end
    end
  end

  // Lane offset in bits: byte -> addr[1:0]*8, half -> addr[1]*16.
  assign shamt = (size_q == 2'b01) ? SW'({addr_q[1], 4'b0000}) : SW'({addr_q[1:0], 3'b000});
  assign shifted = mem_rd >> shamt;
  assign mask = (size_q == 2'b01) ? (DATA_WIDTH'(16'hFFFF) << shamt)
                                  : (DATA_WIDTH'(8'hFF) << shamt);
  assign merged = (mem_rd & ~mask) | ((wdata_q << shamt) & mask);
  assign port_hot = port_q ? 2'b10 : 2'b01;

  always_comb begin
    extracted = mem_rd;
    case (size_q)
      2'b00: extracted = uns_q ? {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]}
                               : {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      2'b01: extracted = uns_q ? {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]}
                               : {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      default: extracted = mem_rd;
    endcase
  end

  always_comb begin
    state_nx = state;
    ack_o    = '0;
    err_o    = '0;
    rdata_o  = '0;
    mem_we   = 1'b0;
    mem_wd   = '0;
    mem_a    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    busy_o   = (state != IDLE);
    case (state)
      IDLE: begin
        if (req_i != 2'b00) begin
          if (!gnt_ok)
            state_nx = ERR;
          else if (we_i[gnt_port] && gnt_size == 2'b10)
            state_nx = WR;
          else
            state_nx = RD;
        end
      end
      WR: begin
        mem_we   = 1'b1;
        mem_wd   = wdata_q;
        ack_o    = port_hot;
        state_nx = IDLE;
      end
      RD: state_nx = we_q ? MERGE : RESP;
      RESP: begin
        ack_o    = port_hot;
        rdata_o  = extracted;
        state_nx = IDLE;
      end
      MERGE: begin
        mem_we   = 1'b1;
        mem_wd   = merged;
        ack_o    = port_hot;
        state_nx = IDLE;
      end
      ERR: begin
        ack_o    = port_hot;
        err_o    = port_hot;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural synchronous-read RAM.
module tb_dmem_arbiter;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req, we, uns;
  logic [1:0][1:0]   sz;
  logic [1:0][31:0]  addr, wdata;
  logic [1:0]        ack_o, err_o;
  logic [31:0]       rdata_o;
  logic              busy_o, mem_we;
  logic [31:0]       mem_a, mem_wd, mem_rd;

  logic [31:0] ram [0:63];
  int tests = 0;
  int fails = 0;
  int we_cnt = 0;
  int seq [0:3];
  int nack;
  int snap;

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .size_i(sz), .uns_i(uns),
    .addr_i(addr), .wdata_i(wdata), .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o),
    .busy_o(busy_o), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_a[7:2]] <= mem_wd;
    mem_rd <= ram[mem_a[7:2]];
  end

  always @(negedge clk) if (mem_we === 1'b1) we_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic txn(input string tag, input int p, input logic twe, input logic [1:0] tsz,
                     input logic tuns, input logic [31:0] ta, input logic [31:0] twd,
                     input int exp_lat, input logic exp_err, input logic chk_rd,
                     input logic [31:0] exp_rd);
    int n;
    logic got;
    logic [1:0] hot;
    hot = (p == 1) ? 2'b10 : 2'b01;
    we[p] = twe; sz[p] = tsz; uns[p] = tuns; addr[p] = ta; wdata[p] = twd;
    req[p] = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 10) begin
      @(posedge clk); #1;
      n++;
      if (ack_o != 2'b00) got = 1'b1;
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " ack"}, {30'd0, ack_o}, {30'd0, hot});
    check({tag, " err"}, {30'd0, err_o}, exp_err ? {30'd0, hot} : 32'd0);
    if (chk_rd) check({tag, " rdata"}, rdata_o, exp_rd);
    req[p] = 1'b0;
    @(posedge clk); #1;
    check({tag, " idle"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0; we = '0; uns = '0; sz = '0; addr = '0; wdata = '0;
    #3;
    check("rst ack", {30'd0, ack_o}, 32'd0);
    check("rst err", {30'd0, err_o}, 32'd0);
    check("rst rdata", rdata_o, 32'd0);
    check("rst busy", {31'd0, busy_o}, 32'd0);
    check("rst mem_we", {31'd0, mem_we}, 32'd0);
    check("rst mem_a", mem_a, 32'd0);
    check("rst mem_wd", mem_wd, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word store then word load, port 0
    txn("st_w", 0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1, 1'b0, 1'b0, 32'h0);
    check("ram 0x10", ram[4], 32'hDEADBEEF);
    txn("ld_w", 0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 1'b1, 32'hDEADBEEF);

    // Byte RMW on port 1
    txn("pre20", 0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 1, 1'b0, 1'b0, 32'h0);
    txn("st_b", 1, 1'b1, 2'b00, 1'b0, 32'h22, 32'h123456AA, 2, 1'b0, 1'b0, 32'h0);
    check("ram 0x20", ram[8], 32'h11AA3344);
    txn("ld_bs", 1, 1'b0, 2'b00, 1'b0, 32'h22, 32'h0, 2, 1'b0, 1'b1, 32'hFFFFFFAA);
    txn("ld_bu", 0, 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 2, 1'b0, 1'b1, 32'h00000011);

    // Misaligned half and illegal size
    snap = we_cnt;
    txn("ld_h_mis", 0, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 1, 1'b1, 1'b1, 32'h0);
    txn("st_sz11", 1, 1'b1, 2'b11, 1'b0, 32'h20, 32'hFFFFFFFF, 1, 1'b1, 1'b0, 32'h0);
    txn("st_w_mis", 0, 1'b1, 2'b10, 1'b0, 32'h22, 32'hFFFFFFFF, 1, 1'b1, 1'b0, 32'h0);
    check("err no we", we_cnt, snap);
    check("ram 0x20 kept", ram[8], 32'h11AA3344);

    // Half RMW
    txn("pre30", 1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h0, 1, 1'b0, 1'b0, 32'h0);
    txn("st_h", 0, 1'b1, 2'b01, 1'b0, 32'h32, 32'hFFFFBEEF, 2, 1'b0, 1'b0, 32'h0);
    check("ram 0x30", ram[12], 32'hBEEF0000);
    txn("ld_hu", 1, 1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 2, 1'b0, 1'b1, 32'h0000BEEF);
    txn("ld_hs", 0, 1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 2, 1'b0, 1'b1, 32'hFFFFBEEF);

    // Reset asserted while a byte store sits in RD
    txn("pre60", 0, 1'b1, 2'b10, 1'b0, 32'h60, 32'h55667788, 1, 1'b0, 1'b0, 32'h0);
    we[1] = 1'b1; sz[1] = 2'b00; uns[1] = 1'b0; addr[1] = 32'h61; wdata[1] = 32'h99;
    req[1] = 1'b1;
    @(posedge clk); #1;
    check("rd busy", {31'd0, busy_o}, 32'd1);
    check("rd mem_we", {31'd0, mem_we}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst ack", {30'd0, ack_o}, 32'd0);
    check("arst busy", {31'd0, busy_o}, 32'd0);
    check("arst mem_we", {31'd0, mem_we}, 32'd0);
    check("arst mem_a", mem_a, 32'd0);
    check("arst mem_wd", mem_wd, 32'd0);
    req = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ram 0x60 kept", ram[24], 32'h55667788);

    // Continuous tie after reset: port 0 first, then alternate
    for (int k = 0; k < 4; k++) seq[k] = 3;
    nack = 0;
    we = 2'b11; sz[0] = 2'b10; sz[1] = 2'b10; uns = '0;
    addr[0] = 32'h40; addr[1] = 32'h44; wdata[0] = 32'h100; wdata[1] = 32'h200;
    req = 2'b11;
    for (int c = 0; c < 20 && nack < 4; c++) begin
      @(posedge clk); #1;
      if (ack_o != 2'b00) begin
        seq[nack] = (ack_o == 2'b10) ? 1 : (ack_o == 2'b01) ? 0 : 2;
        nack++;
      end
    end
    req = '0;
    @(posedge clk); #1;
    check("rr count", nack, 4);
    check("rr grant0", seq[0], 0);
    check("rr grant1", seq[1], 1);
    check("rr grant2", seq[2], 0);
    check("rr grant3", seq[3], 1);
    check("ram 0x40", ram[16], 32'h100);
    check("ram 0x44", ram[17], 32'h200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
